// File: rtl/npl_prog_loader_if.sv
// npl_prog_loader_if: byte stream in, memory write port and load status out.
interface npl_prog_loader_if #(parameter int WIDTH = 32, parameter int ADDRSIZE = 12);
  logic                in_valid;
  logic [7:0]          in_data;
  logic                in_ready;
  logic                mem_we;
  logic [ADDRSIZE-1:0] mem_addr;
  logic [WIDTH-1:0]    mem_wdata;
  logic                cpu_run;
  logic                done;
  logic                err;
  logic [1:0]          err_code;
  logic [ADDRSIZE:0]   words_loaded;
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_run, done, err, err_code, words_loaded
  );
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_run, done, err, err_code, words_loaded
  );
endinterface

// File: rtl/npl_prog_loader.sv
// npl_prog_loader: loads a framed, checksummed byte image into NPL memory, then releases the CPU.
// Define NPL_LOADER_OPCHECK_EN to reject words whose opcode is above HLT (err_code 3).
module npl_prog_loader #(
  parameter int         WIDTH     = 32,
  parameter int         ADDRSIZE  = 12,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic clk,
  input logic reset,
  npl_prog_loader_if.slave bus
);
  localparam int BPW     = WIDTH / 8;
  localparam int BIW     = BPW > 1 ? $clog2(BPW) : 1;
  localparam int MEMSIZE = 1 << ADDRSIZE;
  typedef enum logic [2:0] {S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_CKSUM, S_DONE, S_ERROR} state_t;
  state_t              r_state, w_nxt;
  logic [15:0]         r_cnt;
  logic [7:0]          r_xor;
  logic [WIDTH-1:0]    r_word;
  logic [BIW-1:0]      r_bidx;
  logic [ADDRSIZE-1:0] r_addr;
  logic [ADDRSIZE:0]   r_words;
  logic                r_we;
  logic [ADDRSIZE-1:0] r_mem_addr;
  logic [WIDTH-1:0]    r_mem_wdata;
  logic [1:0]          r_err_code, w_err_code;
  logic                w_acc, w_last_byte, w_last_word, w_bad;
  logic [15:0]         w_cnt;
  logic [WIDTH-1:0]    w_word;
  assign w_acc       = bus.in_valid & bus.in_ready;
  assign w_cnt       = {r_cnt[7:0], bus.in_data};
  assign w_word      = WIDTH'({r_word, bus.in_data});
  assign w_last_byte = r_bidx == BIW'(BPW - 1);
  assign w_last_word = 16'(r_words) + 16'd1 == r_cnt;
`ifdef NPL_LOADER_OPCHECK_EN
  assign w_bad = w_word[WIDTH-1 -: 4] > 4'b1001;
`else
  assign w_bad = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_nxt;
  end
  always_comb begin
    w_nxt      = r_state;
    w_err_code = r_err_code;
    if (w_acc) begin
      case (r_state)
        S_IDLE:   w_nxt = bus.in_data == SYNC_BYTE ? S_CNT_HI : S_IDLE;
        S_CNT_HI: w_nxt = S_CNT_LO;
        S_CNT_LO: begin
          w_nxt      = {1'b0, w_cnt} > 17'(MEMSIZE) ? S_ERROR : w_cnt == 16'd0 ? S_CKSUM : S_DATA;
          w_err_code = {1'b0, w_cnt} > 17'(MEMSIZE) ? 2'd2 : r_err_code;
        end
        S_DATA: begin
          w_nxt      = !w_last_byte ? S_DATA : w_bad ? S_ERROR : w_last_word ? S_CKSUM : S_DATA;
          w_err_code = w_last_byte && w_bad ? 2'd3 : r_err_code;
        end
        S_CKSUM: begin
          w_nxt      = bus.in_data == r_xor ? S_DONE : S_ERROR;
          w_err_code = bus.in_data == r_xor ? r_err_code : 2'd1;
        end
        default: w_nxt = r_state;
      endcase
    end
  end
  always_comb begin
    bus.in_ready     = !(r_state inside {S_DONE, S_ERROR});
    bus.done         = r_state == S_DONE;
    bus.cpu_run      = r_state == S_DONE;
    bus.err          = r_state == S_ERROR;
    bus.err_code     = r_err_code;
    bus.mem_we       = r_we;
    bus.mem_addr     = r_mem_addr;
    bus.mem_wdata    = r_mem_wdata;
    bus.words_loaded = r_words;
  end
  // A completed word is registered here so the write lands one cycle after its last byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_xor       <= '0;
      r_word      <= '0;
      r_bidx      <= '0;
      r_addr      <= '0;
      r_words     <= '0;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_err_code  <= '0;
    end else begin
      r_we       <= 1'b0;
      r_err_code <= w_err_code;
      if (w_acc && (r_state == S_CNT_HI || r_state == S_CNT_LO)) begin
        r_cnt <= w_cnt;
        r_xor <= r_xor ^ bus.in_data;
      end
      if (w_acc && r_state == S_DATA) begin
        r_xor  <= r_xor ^ bus.in_data;
        r_word <= w_word;
        r_bidx <= w_last_byte ? '0 : r_bidx + BIW'(1);
        if (w_last_byte && !w_bad) begin
          r_we        <= 1'b1;
          r_mem_addr  <= r_addr;
          r_mem_wdata <= w_word;
          r_addr      <= r_addr + ADDRSIZE'(1);
          r_words     <= r_words + (ADDRSIZE + 1)'(1);
        end
      end
    end
  end
endmodule

// File: doc/npl_prog_loader.md
Name: npl_prog_loader

Overview:
- Writer side of the instruction/data memory consumed by the NPL CPU.
- Receives a byte-serial program image over a valid/ready stream and checks framing and a checksum.
- Assembles big-endian WIDTH-bit words and writes them sequentially into MEM from address 0.
- Holds the CPU in reset until a clean image has loaded, then asserts cpu_run.

Parameters:
- WIDTH, 32: memory word width; must be a multiple of 8; bytes per word BPW = WIDTH/8.
- ADDRSIZE, 12: memory address width; MEMSIZE = 1<<ADDRSIZE.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-low.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid & in_ready at a clk edge.
- mem_we  out  1  one-cycle memory write strobe.
- mem_addr  out  ADDRSIZE  write address.
- mem_wdata  out  WIDTH  write data.
- cpu_run  out  1  1 = release CPU reset.
- done  out  1  image loaded and checksum good.
- err  out  1  load failed (sticky).
- err_code  out  2  0 none, 1 bad checksum, 2 count > MEMSIZE, 3 illegal opcode (feature only).
- words_loaded  out  ADDRSIZE+1  count of words written.

Behaviour:
- Frame format: SYNC_BYTE, CNT_HI, CNT_LO, then N=CNT words of BPW bytes each (MSB byte first), then CKSUM.
- CKSUM = XOR of CNT_HI, CNT_LO and all data bytes.
- Reset (reset==0 at clk edge): state IDLE; all outputs 0 except in_ready=1; byte index, word address and running XOR all cleared. Reset applied mid-frame aborts the frame with no further writes.
- IDLE: accepted bytes != SYNC_BYTE are discarded; SYNC_BYTE -> CNT_HI.
- CNT_HI: latch byte, XOR into checksum -> CNT_LO.
- CNT_LO: latch byte, XOR into checksum. Then:
  - N > MEMSIZE -> ERROR, err_code=2.
  - N == 0 -> CKSUM.
  - otherwise -> DATA.
- DATA: shift each accepted byte into the word register and XOR it into the checksum.
  - On the BPW-th byte: the next cycle drives mem_we=1, mem_addr=word address, mem_wdata=assembled word; then word address +1 and words_loaded +1.
  - After word N is written -> CKSUM.
  - Write latency is 1 cycle after the last byte of the word.
  - in_ready stays 1 in DATA; back-to-back bytes sustain 1 byte/cycle.
  - The write of word k overlaps reception of word k+1 bytes.
- CKSUM: accepted byte == running XOR -> DONE, else -> ERROR with err_code=1.
- DONE: done=1, cpu_run=1, in_ready=0. Held until reset.
- ERROR: err=1, cpu_run=0, in_ready=0, err_code held. Exit by reset only.
- in_ready=1 in IDLE, CNT_HI, CNT_LO, DATA, CKSUM.
- Bubbles (in_valid=0) stall without state change; no timeout.
- N == MEMSIZE: the last write goes to address MEMSIZE-1; the internal word address wraps to 0 but is not reused.
- mem_addr and mem_wdata hold their last values when mem_we=0.

Optional Feature:
- Macro: NPL_LOADER_OPCHECK_EN.
- When defined, each assembled word's opcode field word[WIDTH-1:WIDTH-4] is checked before writing. If the opcode is > 4'b1001 (HLT):
  - no mem_we is issued for that word;
  - state -> ERROR with err_code=3;
  - words_loaded shows the number of good words written before it.
- When undefined, all opcodes are written unchecked and err_code=3 is never produced.

Test Plan:
- Bytes 33, A5, 00, 02, 28, 00, 10, 01, 90, 00, 00, 00, AB -> byte 33 ignored; write 0x28001001 @0, then 0x90000000 @1; done=1, cpu_run=1, words_loaded=2, in_ready=0.
- Same frame with last byte AA -> both writes occur; err=1, err_code=1, cpu_run=0, done=0.
- A5, 10, 01 (N=4097, ADDRSIZE=12) -> ERROR after CNT_LO, err_code=2, no mem_we ever.
- A5, 00, 00, 00 -> done=1, words_loaded=0, no writes.
- Frame of N=3 with in_valid toggled every other cycle, then reset pulsed low after the 6th data byte -> exactly one write (@0); all outputs at reset values afterward; a fresh valid frame then loads correctly.
- With NPL_LOADER_OPCHECK_EN: A5, 00, 02, 90, 00, 00, 00, F0, 00, 00, 00, ... -> write 0x90000000 @0; second word (opcode F) not written; err_code=3, words_loaded=1.
